ula: RTL and testbench
======================

Name: ula

Overview:
- 32-bit registered arithmetic/logic unit for the LABIII processor datapath.
- Decodes a 5-bit opcode from inst[31:27] and computes a result from operand_a and operand_b.
- Produces compare flags (equal/above/below), an overflow flag and an error flag.
- All outputs are registered: one-cycle latency from inputs to outputs.

Parameters:
- WIDTH, 32, operand/result width; all other widths are fixed to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- operand_a  input  32  first operand.
- operand_b  input  32  second operand.
- inst  input  32  instruction word; only inst[31:27] (opcode) is used, other bits are ignored.
- result  output  32  registered operation result.
- equal  output  1  registered: operand_a == operand_b.
- above  output  1  registered: operand_a > operand_b, unsigned.
- below  output  1  registered: operand_a < operand_b, unsigned.
- overflow  output  1  registered overflow for the current operation.
- error  output  1  registered: unsupported opcode or divide by zero.

Behaviour:
- Reset: at a rising clk edge with rst_n=0, result, equal, above, below, overflow and error are all cleared to 0. Reset has priority over any in-flight computation.
- Latency: outputs update at every rising edge (rst_n=1) from the inputs sampled at that edge. Outputs are held between edges. There is no handshake; a new operation may be issued every cycle.
- Compare flags are computed every cycle regardless of opcode, unsigned. Exactly one of equal/above/below is 1 (after reset).
- Opcode map, op = inst[31:27]:
  - 0 NOP: result=0, overflow=0, error=0.
  - 3 ADD: result=(a+b)[31:0]; overflow = unsigned carry-out of bit 31.
  - 4 SUB: result=(a-b)[31:0]; overflow = unsigned borrow (a<b).
  - 5 MUL: unsigned 64-bit product; result=low 32 bits; overflow=1 if the high 32 bits are nonzero.
  - 6 DIV: signed two's-complement quotient, truncated toward zero.
    - b==0: result=0, error=1, overflow=0.
    - a==0x80000000 and b==0xFFFFFFFF: result=0x80000000, overflow=1.
  - 7 AND: a&b.
  - 8 OR: a|b.
  - 9 XOR: a^b.
  - 10 NOT: ~a (b ignored).
  - 11 SHL: a << b[4:0].
  - 12 SHR: logical a >> b[4:0].
  - 13 SRA: arithmetic a >>> b[4:0].
  - Ops 7–13 always drive overflow=0.
  - Any other opcode: result=0, overflow=0, error=1.
- error and overflow are never both 1 in the same cycle.
- Division is combinational (single cycle); no multi-cycle divider.

Optional Feature:
- Macro ULA_MOD_EN.
- Defined: opcode 14 MOD gives the signed remainder (sign follows dividend).
  - b==0: result=0, error=1.
  - a==0x80000000 and b==0xFFFFFFFF: result=0, overflow=0.
- Undefined: opcode 14 is unsupported (result=0, error=1).

Test Plan:
- Reset: drive rst_n=0 for 2 edges with op=3, a=5, b=8 -> all outputs 0. Release -> next edge result=13.
- ADD/SUB:
  - op3, a=5, b=8 -> result=13, overflow=0, below=1.
  - op3, a=0xFFFFFFFF, b=1 -> result=0, overflow=1, above=1.
  - op4, a=10, b=3 -> result=7, overflow=0.
  - op4, a=1, b=0xFFFFFFFF -> result=2, overflow=1.
- MUL:
  - op5, a=2, b=8 -> result=16, overflow=0.
  - op5, a=2, b=0xFFFFFFFF -> result=0xFFFFFFFE, overflow=1.
- DIV:
  - op6, a=28, b=4 -> result=7.
  - op6, a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, overflow=1, error=0.
  - op6, a=9, b=0 -> result=0, error=1.
- Logic/shift:
  - op7, a=1, b=1 -> result=1, equal=1.
  - op10, a=0 -> result=0xFFFFFFFF.
  - op13, a=0x80000000, b=4 -> result=0xF8000000.
- Illegal/back-to-back:
  - op31 -> error=1, result=0.
  - Issue ADD then SUB on consecutive cycles -> each result appears exactly one cycle after its inputs.
  - With ULA_MOD_EN, op14, a=-7, b=2 -> result=0xFFFFFFFF.

Source files
------------

// File: rtl/ula.sv
// ula: registered 32-bit arithmetic/logic unit with unsigned compare flags, overflow and error.
// Optional macro ULA_MOD_EN enables opcode 14 (signed remainder); otherwise opcode 14 flags error.
`default_nettype none

module ula #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [31:0]      inst,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             above,
  output logic             below,
  output logic             overflow,
  output logic             error
);

  localparam logic [4:0] c_op_nop = 5'd0;
  localparam logic [4:0] c_op_add = 5'd3;
  localparam logic [4:0] c_op_sub = 5'd4;
  localparam logic [4:0] c_op_mul = 5'd5;
  localparam logic [4:0] c_op_div = 5'd6;
  localparam logic [4:0] c_op_and = 5'd7;
  localparam logic [4:0] c_op_or  = 5'd8;
  localparam logic [4:0] c_op_xor = 5'd9;
  localparam logic [4:0] c_op_not = 5'd10;
  localparam logic [4:0] c_op_shl = 5'd11;
  localparam logic [4:0] c_op_shr = 5'd12;
  localparam logic [4:0] c_op_sra = 5'd13;
`ifdef ULA_MOD_EN
  localparam logic [4:0] c_op_mod = 5'd14;
`endif

  localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_neg_one = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [4:0]         w_op;
  logic               w_unused;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_div_b;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [4:0]         w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_err;

  logic [WIDTH-1:0]   r_result;
  logic               r_equal;
  logic               r_above;
  logic               r_below;
  logic               r_overflow;
  logic               r_error;

  assign w_op     = inst[31:27];
  assign w_unused = ^inst[26:0];
  assign w_shamt  = operand_b[4:0];

  assign w_sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign w_diff = operand_a - operand_b;
  assign w_prod = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};

  // The divisor is forced to 1 for b==0 and INT_MIN/-1 so the divider never sees an
  // undefined case; INT_MIN/1 and INT_MIN%1 already give the required special results.
  assign w_div_zero = (operand_b == '0);
  assign w_div_ovf  = (operand_a == c_int_min) && (operand_b == c_neg_one);
  assign w_div_b    = (w_div_zero || w_div_ovf) ? c_one : operand_b;
  assign w_quot     = $signed(operand_a) / $signed(w_div_b);
  assign w_rem      = $signed(operand_a) % $signed(w_div_b);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (w_op)
      c_op_nop: ;
      c_op_add: begin
        w_res = w_sum[WIDTH-1:0];
        w_ovf = w_sum[WIDTH];
      end
      c_op_sub: begin
        w_res = w_diff;
        w_ovf = (operand_a < operand_b);
      end
      c_op_mul: begin
        w_res = w_prod[WIDTH-1:0];
        w_ovf = |w_prod[2*WIDTH-1:WIDTH];
      end
      c_op_div: begin
        if (w_div_zero) begin
          w_err = 1'b1;
        end else begin
          w_res = w_quot;
          w_ovf = w_div_ovf;
        end
      end
      c_op_and: w_res = operand_a & operand_b;
      c_op_or:  w_res = operand_a | operand_b;
      c_op_xor: w_res = operand_a ^ operand_b;
      c_op_not: w_res = ~operand_a;
      c_op_shl: w_res = operand_a << w_shamt;
      c_op_shr: w_res = operand_a >> w_shamt;
      c_op_sra: w_res = $signed(operand_a) >>> w_shamt;
`ifdef ULA_MOD_EN
      c_op_mod: begin
        if (w_div_zero) begin
          w_err = 1'b1;
        end else begin
          w_res = w_rem;
        end
      end
`endif
      default:  w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_equal    <= 1'b0;
      r_above    <= 1'b0;
      r_below    <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_result   <= w_res;
      r_equal    <= (operand_a == operand_b);
      r_above    <= (operand_a > operand_b);
      r_below    <= (operand_a < operand_b);
      r_overflow <= w_ovf;
      r_error    <= w_err;
    end
  end

  assign result   = r_result;
  assign equal    = r_equal;
  assign above    = r_above;
  assign below    = r_below;
  assign overflow = r_overflow;
  assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ula.sv
// tb_ula: scoreboard bench for ula; flag vector order is {equal, above, below, overflow, error}.
`default_nettype none

module tb_ula;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] inst;
  logic [31:0] result;
  logic        equal;
  logic        above;
  logic        below;
  logic        overflow;
  logic        error;

  int n_total;
  int n_bad;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t sb_q[$];

  ula #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .inst      (inst),
    .result    (result),
    .equal     (equal),
    .above     (above),
    .below     (below),
    .overflow  (overflow),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic        ov;
    logic        er;
    logic [31:0] r;
    longint      sa;
    longint      sb;
    r  = 0;
    ov = 0;
    er = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0: ;
      5'd3: begin p = 64'(a) + 64'(b); r = p[31:0]; ov = p[32]; end
      5'd4: begin r = a - b; ov = (a < b); end
      5'd5: begin p = 64'(a) * 64'(b); r = p[31:0]; ov = (p[63:32] != 0); end
      5'd6: begin
        if (b == 0) er = 1;
        else begin
          p  = 64'(sa / sb);
          r  = p[31:0];
          ov = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        end
      end
      5'd7:  r = a & b;
      5'd8:  r = a | b;
      5'd9:  r = a ^ b;
      5'd10: r = ~a;
      5'd11: r = a << b[4:0];
      5'd12: r = a >> b[4:0];
      5'd13: r = $signed(a) >>> b[4:0];
`ifdef ULA_MOD_EN
      5'd14: begin
        if (b == 0) er = 1;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
`endif
      default: er = 1;
    endcase
    e.res = r;
    e.flg = {a == b, a > b, a < b, ov, er};
    return e;
  endfunction

  // Drive on the falling edge, push the expectation, then check one edge later.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic [4:0] exp_flg);
    exp_t e;
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    inst      = {op, 27'h5A5_A5A5};
    e.res     = exp_res;
    e.flg     = exp_flg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_res"}, result, e.res);
      chk({tag, "_flg"}, {27'd0, equal, above, below, overflow, error}, {27'd0, e.flg});
    end
  endtask

  task automatic issue_model(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    issue(tag, op, a, b, e.res, e.flg);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    operand_a = 32'd5;
    operand_b = 32'd8;
    inst      = {5'd3, 27'd0};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_res", result, 32'd0);
    chk("rst_flg", {27'd0, equal, above, below, overflow, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add_small",  5'd3,  32'd5,          32'd8,          32'd13,         5'b00100);
    issue("add_carry",  5'd3,  32'hFFFF_FFFF,  32'd1,          32'd0,          5'b01010);
    issue("sub_small",  5'd4,  32'd10,         32'd3,          32'd7,          5'b01000);
    issue("sub_borrow", 5'd4,  32'd1,          32'hFFFF_FFFF,  32'd2,          5'b00110);
    issue("mul_small",  5'd5,  32'd2,          32'd8,          32'd16,         5'b00100);
    issue("mul_ovf",    5'd5,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'b00110);
    issue("div_pos",    5'd6,  32'd28,         32'd4,          32'd7,          5'b01000);
    issue("div_ovf",    5'd6,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  5'b00110);
    issue("div_zero",   5'd6,  32'd9,          32'd0,          32'd0,          5'b01001);
    issue("div_neg",    5'd6,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  5'b01000);
    issue("and_eq",     5'd7,  32'd1,          32'd1,          32'd1,          5'b10000);
    issue("or",         5'd8,  32'h0F0F_0000,  32'h0000_F0F0,  32'h0F0F_F0F0,  5'b01000);
    issue("xor",        5'd9,  32'hFF00_FF00,  32'hFFFF_0000,  32'h00FF_FF00,  5'b00100);
    issue("not",        5'd10, 32'd0,          32'd0,          32'hFFFF_FFFF,  5'b10000);
    issue("shl_wrap",   5'd11, 32'd1,          32'd33,         32'd2,          5'b00100);
    issue("shr",        5'd12, 32'h8000_0000,  32'd4,          32'h0800_0000,  5'b01000);
    issue("sra",        5'd13, 32'h8000_0000,  32'd4,          32'hF800_0000,  5'b01000);
    issue("illegal31",  5'd31, 32'd3,          32'd3,          32'd0,          5'b10001);
    issue("nop",        5'd0,  32'd5,          32'd5,          32'd0,          5'b10000);
`ifdef ULA_MOD_EN
    issue("mod_neg",    5'd14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  5'b01000);
    issue("mod_min",    5'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          5'b00100);
    issue("mod_zero",   5'd14, 32'd7,          32'd0,          32'd0,          5'b01001);
`else
    issue("op14_illegal", 5'd14, 32'hFFFF_FFF9, 32'd2,         32'd0,          5'b01001);
`endif
    issue("b2b_add",    5'd3,  32'd100,        32'd23,         32'd123,        5'b01000);
    issue("b2b_sub",    5'd4,  32'd100,        32'd23,         32'd77,         5'b01000);

    for (int i = 0; i < 200; i++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 5'($urandom_range(0, 15));
      a  = $urandom();
      b  = (i % 4 == 0) ? a : $urandom();
      if (i % 7 == 0) b = b & 32'h0000_000F;
      issue_model("rand", op, a, b);
    end

    // Reset asserted mid-stream must override a pending computation.
    @(negedge clk);
    rst_n     = 1'b0;
    operand_a = 32'hFFFF_FFFF;
    operand_b = 32'd1;
    inst      = {5'd31, 27'd0};
    @(posedge clk);
    #1;
    chk("rst2_res", result, 32'd0);
    chk("rst2_flg", {27'd0, equal, above, below, overflow, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst", 5'd3, 32'd5, 32'd8, 32'd13, 5'b00100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
